// File: rtl/shiftreg_seq_pkg.sv
// shiftreg_seq_pkg
// Shared encodings for the shift-register command sequencer and the
// universal shift register it drives: MODO control codes, command opcodes
// and sequencer FSM states. The shift-register datapath uses the same
// MODO constants, so both sides always agree on the control encoding.
package shiftreg_seq_pkg;

  // MODO encodings seen by the shift register
  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  // CMD_OP encodings
  typedef enum logic [1:0] {
    OP_TX   = 2'b00,
    OP_RX   = 2'b01,
    OP_ROT  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shiftreg_seq.sv
// shiftreg_seq
// Command sequencer for a WIDTH-bit universal shift register. Accepts one
// command (TX, RX, ROT, LOAD) over a valid/ready handshake, steps the
// register's control inputs cycle by cycle, and returns the final register
// contents over a valid/ready response handshake.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_OP/DATA/DIR/CNT   command opcode, TX/LOAD word, direction, rotate count
//   SER_IN                receive bit, sampled on each RX shift edge
//   SER_OUT, SER_STB      transmit bit and strobe for TX/RX shift cycles
//   RSP_VALID/RSP_READY   response handshake, RSP_DATA follows Q
//   ENB, DIR, S_IN, MODO, D   control/data to the shift register
//   Q                     shift register contents
//
// CNT_W must satisfy 2**CNT_W > WIDTH so the bit counter can hold WIDTH.
module shiftreg_seq
  import shiftreg_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic             SER_IN,
  output logic             SER_OUT,
  output logic             SER_STB,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             ENB,
  output logic             DIR,
  output logic             S_IN,
  output logic [1:0]       MODO,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rdy;
  logic             accept;

  // Latched command; data-path registers, only written on accept
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;

  assign accept = rdy && CMD_VALID;

  // Control state: FSM, bit counter and ready flag.
  // rdy mirrors "next state is IDLE" so CMD_READY is a plain flop output;
  // it is forced low by reset and rises the cycle after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy   <= (state_nxt == ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_t'(CMD_OP);
      data_q <= CMD_DATA;
      dir_q  <= CMD_DIR;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_t'(CMD_OP))
            OP_TX, OP_LOAD: state_nxt = ST_LOAD;
            OP_RX: begin
              state_nxt = ST_SHIFT;
              cnt_nxt   = CNT_FULL;
            end
            default: begin
              // ROT: a zero count skips the shift phase entirely
              if (CMD_CNT == '0) begin
                state_nxt = ST_DONE;
              end else begin
                state_nxt = ST_SHIFT;
                cnt_nxt   = CMD_CNT;
              end
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (op_q == OP_TX) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = CNT_FULL;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
        cnt_nxt = cnt - 1'b1;
        // <= 1 also guards against a corrupted zero count looping forever
        if (cnt <= CNT_W'(1)) state_nxt = ST_DONE;
      end
      default: begin
        if (RSP_READY) state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state and latched command
  always_comb begin
    CMD_READY = rdy;
    RSP_DATA  = Q;
    ENB       = 1'b0;
    MODO      = MODO_HOLD;
    DIR       = 1'b0;
    S_IN      = 1'b0;
    D         = '0;
    SER_OUT   = 1'b0;
    SER_STB   = 1'b0;
    RSP_VALID = 1'b0;
    case (state)
      ST_LOAD: begin
        ENB  = 1'b1;
        MODO = MODO_LOAD;
        D    = data_q;
      end
      ST_SHIFT: begin
        ENB = 1'b1;
        DIR = dir_q;
        if (op_q == OP_ROT) begin
          MODO = MODO_ROT;
        end else begin
          MODO    = MODO_SHIFT;
          SER_STB = 1'b1;
        end
        if (op_q == OP_RX) S_IN = SER_IN;
        // The bit about to leave the register on this shift edge
        if (op_q == OP_TX) SER_OUT = dir_q ? Q[0] : Q[WIDTH-1];
      end
      ST_DONE: begin
        RSP_VALID = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shiftreg_seq.sv
// tb_shiftreg_seq
// Testbench for shiftreg_seq with a behavioural 4-bit universal shift
// register on Q. Expected responses are queued when a command is issued and
// compared when the sequencer raises RSP_VALID.
module tb_shiftreg_seq;
  import shiftreg_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             CMD_VALID, CMD_READY;
  logic [1:0]       CMD_OP;
  logic [WIDTH-1:0] CMD_DATA;
  logic             CMD_DIR;
  logic [CNT_W-1:0] CMD_CNT;
  logic             SER_IN, SER_OUT, SER_STB;
  logic             RSP_VALID, RSP_READY;
  logic [WIDTH-1:0] RSP_DATA;
  logic             ENB, DIR, S_IN;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] q_reg = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] data;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shiftreg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_DATA(CMD_DATA), .CMD_DIR(CMD_DIR), .CMD_CNT(CMD_CNT),
    .SER_IN(SER_IN), .SER_OUT(SER_OUT), .SER_STB(SER_STB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D), .Q(q_reg)
  );

  // Shift register datapath
  always @(posedge clk) begin
    if (ENB) begin
      case (MODO)
        MODO_SHIFT: q_reg <= DIR ? {S_IN, q_reg[3:1]} : {q_reg[2:0], S_IN};
        MODO_ROT:   q_reg <= DIR ? {q_reg[0], q_reg[3:1]} : {q_reg[2:0], q_reg[3]};
        MODO_LOAD:  q_reg <= D;
        default:    ;
      endcase
    end
  end

  function automatic logic [3:0] rot_model(input logic [3:0] q, input logic dir, input int n);
    logic [3:0] r;
    r = q;
    for (int i = 0; i < n; i++) r = dir ? {r[0], r[3:1]} : {r[2:0], r[3]};
    return r;
  endfunction

  // Issue one command from a negedge; returns what was observed.
  // lat counts cycles after the accept edge (first cycle = 1) until RSP_VALID.
  // txb collects SER_OUT on strobe cycles, first bit ending up in the MSB.
  // sin supplies SER_IN bits, MSB first.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic dir,
                         input logic [2:0] cnt, input logic [3:0] sin, input bit release_rsp,
                         output logic [3:0] txb, output int nstb, output int nenb,
                         output int lat, output logic [3:0] rsp, output bit ok);
    int k;
    txb = '0; nstb = 0; nenb = 0; lat = 0; rsp = '0; ok = 1'b0;
    CMD_OP = op; CMD_DATA = data; CMD_DIR = dir; CMD_CNT = cnt; CMD_VALID = 1'b1;
    k = 0;
    while (!CMD_READY && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!CMD_READY) begin
      CMD_VALID = 1'b0;
      return;
    end
    @(negedge clk);
    CMD_VALID = 1'b0;
    lat = 1;
    while (lat <= 40) begin
      if (ENB) nenb++;
      if (SER_STB) begin
        txb = {txb[2:0], SER_OUT};
        if (nstb < 4) SER_IN = sin[3-nstb];
        nstb++;
      end
      if (RSP_VALID) break;
      @(negedge clk);
      lat++;
    end
    SER_IN = 1'b0;
    if (!RSP_VALID) return;
    rsp = RSP_DATA;
    ok = 1'b1;
    if (release_rsp) begin
      RSP_READY = 1'b1;
      @(negedge clk);
      RSP_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_DATA = '0; CMD_DIR = 1'b0;
    CMD_CNT = '0; SER_IN = 1'b0; RSP_READY = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", CMD_READY); end
    checks++; if (ENB !== 1'b0) begin errors++; $display("FAIL rst_enb: got %b expected 0", ENB); end
    checks++; if (MODO !== 2'b11) begin errors++; $display("FAIL rst_modo: got %b expected 11", MODO); end
    checks++; if ({DIR, S_IN, SER_OUT, SER_STB, RSP_VALID} !== 5'b0) begin
      errors++; $display("FAIL rst_ctl: DIR/S_IN/SER_OUT/SER_STB/RSP_VALID got %b expected 00000",
                         {DIR, S_IN, SER_OUT, SER_STB, RSP_VALID});
    end
    checks++; if (D !== 4'b0000) begin errors++; $display("FAIL rst_d: got %b expected 0000", D); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", CMD_READY); end
  endtask

  task automatic test_tx();
    exp_t e; logic [3:0] txb, rsp; int nstb, nenb, lat; bit ok;
    sb.push_back('{data: 4'b0000, lat: 6});
    run_cmd(OP_TX, 4'b1011, 1'b0, 3'd0, 4'b0000, 1'b1, txb, nstb, nenb, lat, rsp, ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL tx_done: no response, ok %b expected 1", ok); end
    checks++; if (rsp !== e.data) begin errors++; $display("FAIL tx_data: got %b expected %b", rsp, e.data); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL tx_lat: got %0d expected %0d", lat, e.lat); end
    checks++; if (txb !== 4'b1011) begin errors++; $display("FAIL tx_serout: got %b expected 1011", txb); end
    checks++; if (nstb != 4) begin errors++; $display("FAIL tx_strobes: got %0d expected 4", nstb); end
    checks++; if (nenb != 5) begin errors++; $display("FAIL tx_enb: got %0d expected 5", nenb); end
  endtask

  task automatic test_rx();
    exp_t e; logic [3:0] txb, rsp; int nstb, nenb, lat; bit ok;
    sb.push_back('{data: 4'b0011, lat: 5});
    run_cmd(OP_RX, 4'b0000, 1'b1, 3'd0, 4'b1100, 1'b1, txb, nstb, nenb, lat, rsp, ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL rx_done: no response, ok %b expected 1", ok); end
    checks++; if (rsp !== e.data) begin errors++; $display("FAIL rx_data: got %b expected %b", rsp, e.data); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL rx_lat: got %0d expected %0d", lat, e.lat); end
    checks++; if (txb !== 4'b0000) begin errors++; $display("FAIL rx_serout_quiet: got %b expected 0000", txb); end
    checks++; if (nstb != 4) begin errors++; $display("FAIL rx_strobes: got %0d expected 4", nstb); end
  endtask

  // LOAD 0110 followed by a table of rotates, including count 0 and counts >= WIDTH
  task automatic test_load_rot();
    exp_t e; logic [3:0] txb, rsp, exp_q; int nstb, nenb, lat; bit ok;
    logic       rdir[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] rcnt[5] = '{3'd1, 3'd0, 3'd5, 3'd7, 3'd4};
    sb.push_back('{data: 4'b0110, lat: 2});
    run_cmd(OP_LOAD, 4'b0110, 1'b0, 3'd0, 4'b0000, 1'b1, txb, nstb, nenb, lat, rsp, ok);
    e = sb.pop_front();
    checks++; if (!ok || rsp !== e.data) begin errors++; $display("FAIL load_data: got %b expected %b", rsp, e.data); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL load_lat: got %0d expected %0d", lat, e.lat); end
    exp_q = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      exp_q = rot_model(exp_q, rdir[i], int'(rcnt[i]));
      sb.push_back('{data: exp_q, lat: int'(rcnt[i]) + 1});
      run_cmd(OP_ROT, 4'b0000, rdir[i], rcnt[i], 4'b0000, 1'b1, txb, nstb, nenb, lat, rsp, ok);
      e = sb.pop_front();
      checks++; if (!ok || rsp !== e.data) begin errors++; $display("FAIL rot%0d_data: got %b expected %b", i, rsp, e.data); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL rot%0d_lat: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (nenb != int'(rcnt[i])) begin errors++; $display("FAIL rot%0d_enb: got %0d expected %0d", i, nenb, rcnt[i]); end
    end
  endtask

  task automatic test_hold();
    exp_t e; logic [3:0] txb, rsp; int nstb, nenb, lat; bit ok;
    sb.push_back('{data: 4'b0101, lat: 2});
    run_cmd(OP_LOAD, 4'b0101, 1'b0, 3'd0, 4'b0000, 1'b0, txb, nstb, nenb, lat, rsp, ok);
    e = sb.pop_front();
    checks++; if (!ok || rsp !== e.data) begin errors++; $display("FAIL hold_load: got %b expected %b", rsp, e.data); end
    CMD_OP = OP_LOAD; CMD_DATA = 4'b1010; CMD_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (RSP_VALID !== 1'b1) begin errors++; $display("FAIL hold%0d_valid: got %b expected 1", i, RSP_VALID); end
      checks++; if (RSP_DATA !== e.data) begin errors++; $display("FAIL hold%0d_data: got %b expected %b", i, RSP_DATA, e.data); end
      checks++; if (ENB !== 1'b0) begin errors++; $display("FAIL hold%0d_enb: got %b expected 0", i, ENB); end
      checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL hold%0d_ready: got %b expected 0", i, CMD_READY); end
    end
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(negedge clk);
    RSP_READY = 1'b0;
    @(negedge clk);
    checks++; if (q_reg !== 4'b0101) begin errors++; $display("FAIL hold_ignored_cmd: Q got %b expected 0101", q_reg); end
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL hold_idle_ready: got %b expected 1", CMD_READY); end
  endtask

  task automatic test_mid_reset();
    exp_t e; logic [3:0] txb, rsp; int nstb, nenb, lat, k; bit ok;
    CMD_OP = OP_TX; CMD_DATA = 4'b1010; CMD_DIR = 1'b0; CMD_CNT = '0; CMD_VALID = 1'b1;
    k = 0;
    while (!CMD_READY && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);               // LOAD cycle
    CMD_VALID = 1'b0;
    @(negedge clk);               // first SHIFT cycle
    @(negedge clk);               // second SHIFT cycle
    checks++; if (SER_STB !== 1'b1) begin errors++; $display("FAIL mrst_in_shift: SER_STB got %b expected 1", SER_STB); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ENB !== 1'b0 || MODO !== 2'b11) begin
      errors++; $display("FAIL mrst_ctl: ENB/MODO got %b/%b expected 0/11", ENB, MODO);
    end
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", RSP_VALID); end
    checks++; if (q_reg !== 4'b1000) begin errors++; $display("FAIL mrst_q: got %b expected 1000", q_reg); end
    @(negedge clk);
    checks++; if (q_reg !== 4'b1000) begin errors++; $display("FAIL mrst_q_held: got %b expected 1000", q_reg); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b expected 1", CMD_READY); end
    sb.push_back('{data: 4'b1111, lat: 2});
    run_cmd(OP_LOAD, 4'b1111, 1'b0, 3'd0, 4'b0000, 1'b1, txb, nstb, nenb, lat, rsp, ok);
    e = sb.pop_front();
    checks++; if (!ok || rsp !== e.data) begin errors++; $display("FAIL mrst_load: got %b expected %b", rsp, e.data); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL mrst_load_lat: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int k, c, done_c, acc_c, lat;
    sb.push_back('{data: 4'b0011, lat: 2});
    sb.push_back('{data: rot_model(4'b0011, 1'b1, 2), lat: 3});
    RSP_READY = 1'b1;
    CMD_OP = OP_LOAD; CMD_DATA = 4'b0011; CMD_DIR = 1'b0; CMD_CNT = '0; CMD_VALID = 1'b1;
    k = 0;
    while (!CMD_READY && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    // Second command queued behind the first, CMD_VALID stays high
    CMD_OP = OP_ROT; CMD_DATA = 4'b0000; CMD_DIR = 1'b1; CMD_CNT = 3'd2;
    c = 1; done_c = 0; acc_c = 0;
    e = sb.pop_front();
    while (c < 12) begin
      if (RSP_VALID && done_c == 0) begin
        done_c = c;
        checks++; if (RSP_DATA !== e.data) begin errors++; $display("FAIL b2b_first_data: got %b expected %b", RSP_DATA, e.data); end
        checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 0", CMD_READY); end
      end
      if (CMD_READY) begin acc_c = c; break; end
      @(negedge clk);
      c++;
    end
    checks++; if (done_c != e.lat) begin errors++; $display("FAIL b2b_first_lat: got %0d expected %0d", done_c, e.lat); end
    checks++; if (acc_c != e.lat + 1) begin errors++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc_c, e.lat + 1); end
    @(negedge clk);
    CMD_VALID = 1'b0;
    e = sb.pop_front();
    lat = 1;
    while (!RSP_VALID && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== e.data) begin
      errors++; $display("FAIL b2b_second_data: got %b valid %b expected %b", RSP_DATA, RSP_VALID, e.data);
    end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_second_lat: got %0d expected %0d", lat, e.lat); end
    @(negedge clk);
    RSP_READY = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_load_rot();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
